// File: rtl/eth_pkg.sv
// Shared widths, length limits and scheduler state encoding for the Ethernet TX path.
package eth_pkg;

  localparam int ETH_LEN_W   = 11;
  localparam int ETH_MIN_LEN = 60;
  localparam int ETH_MAX_LEN = 1514;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_SEND,
    ST_GAP
  } txarb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_arb_rr_arbiter.sv
// Combinational rotating-priority picker: search begins one past the last served index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_vld    = 1'b0;
    cand_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = IDX_W'((int'(last) + k) % N_REQ);
      if (!win_vld && req[cand_idx]) begin
        win_vld              = 1'b1;
        win_idx              = cand_idx;
        win_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Round-robin scheduler sharing one Ethernet TX port between N_REQ frame buffers,
// with length validation, launch timeout and an enforced inter-frame gap.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IFG_CYCLES = 96,
  parameter int MIN_LEN    = ETH_MIN_LEN,
  parameter int MAX_LEN    = ETH_MAX_LEN,
  parameter int BUSY_TMO   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ETH_LEN_W-1:0] req_len,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic [N_REQ-1:0]           err,
  output logic [ETH_LEN_W-1:0]       rd_addr,
  input  logic [N_REQ*8-1:0]         rd_data,
  output logic                       tx_vld,
  output logic [ETH_LEN_W-1:0]       tx_count,
  input  logic [ETH_LEN_W-1:0]       tx_addr,
  input  logic                       tx_busy,
  output logic [7:0]                 tx_data
);

  localparam int IDX_W = idx_w(N_REQ);

  txarb_state_t         state_reg;
  logic [IDX_W-1:0]     owner_reg;
  logic [IDX_W-1:0]     last_reg;
  logic [ETH_LEN_W-1:0] len_reg;
  logic [15:0]          tmo_cnt_reg;
  logic [15:0]          gap_cnt_reg;

  logic [N_REQ-1:0]     win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_vld;

  logic [7:0]           rd_bytes [N_REQ];
  logic [ETH_LEN_W-1:0] req_lens [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign rd_bytes[gi] = rd_data[8*gi +: 8];
      assign req_lens[gi] = req_len[ETH_LEN_W*gi +: ETH_LEN_W];
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (req),
    .last       (last_reg),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_vld    (win_vld)
  );

  assign rd_addr = tx_addr;
  assign tx_data = (|grant) ? rd_bytes[owner_reg] : 8'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= '0;
      last_reg    <= IDX_W'(N_REQ - 1);
      len_reg     <= '0;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      grant       <= '0;
      done        <= '0;
      err         <= '0;
      tx_vld      <= 1'b0;
      tx_count    <= '0;
    end else begin
      done   <= '0;
      err    <= '0;
      tx_vld <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (win_vld && !tx_busy) begin
            owner_reg <= win_idx;
            len_reg   <= req_lens[win_idx];
            grant     <= win_onehot;
            state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (int'(len_reg) < MIN_LEN || int'(len_reg) > MAX_LEN) begin
            err       <= grant;
            grant     <= '0;
            last_reg  <= owner_reg;
            state_reg <= ST_IDLE;
          end else begin
            tx_vld    <= 1'b1;
            tx_count  <= len_reg;
            state_reg <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tmo_cnt_reg <= '0;
          state_reg   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // The launch cycle itself counts toward the timeout window.
          if (tx_busy) begin
            state_reg <= ST_SEND;
          end else if (int'(tmo_cnt_reg) + 2 >= BUSY_TMO) begin
            err         <= grant;
            grant       <= '0;
            last_reg    <= owner_reg;
            gap_cnt_reg <= 16'(IFG_CYCLES);
            state_reg   <= ST_GAP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            done        <= grant;
            grant       <= '0;
            last_reg    <= owner_reg;
            gap_cnt_reg <= 16'(IFG_CYCLES);
            state_reg   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == 16'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: event scoreboard plus a behavioural eth stub that walks tx_addr.
module tb_eth_tx_arb;
  import eth_pkg::*;

  localparam int N   = 4;
  localparam int IFG = 12;
  localparam int TMO = 16;

  localparam int K_LAUNCH = 0;
  localparam int K_DONE   = 1;
  localparam int K_ERR    = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [N-1:0]           req = '0;
  logic [N*ETH_LEN_W-1:0] req_len = '0;
  logic [N-1:0]           grant, done, err;
  logic [ETH_LEN_W-1:0]   rd_addr;
  logic [N*8-1:0]         rd_data;
  logic                   tx_vld;
  logic [ETH_LEN_W-1:0]   tx_count;
  logic [ETH_LEN_W-1:0]   tx_addr = '0;
  logic                   tx_busy = 1'b0;
  logic [7:0]             tx_data;

  always #5 clk = ~clk;

  eth_tx_arb #(
    .N_REQ      (N),
    .IFG_CYCLES (IFG),
    .MIN_LEN    (60),
    .MAX_LEN    (1514),
    .BUSY_TMO   (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_len  (req_len),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_vld   (tx_vld),
    .tx_count (tx_count),
    .tx_addr  (tx_addr),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data)
  );

  function automatic logic [7:0] buf_byte(input int i, input int a);
    return 8'(i * 37 + a * 13 + 3);
  endfunction

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N; i++) rd_data[8*i +: 8] = buf_byte(i, int'(rd_addr));
  end

  typedef struct {
    int kind;
    int idx;
    int len;
    int at;   // >=0 absolute cycle, -1 any, -2 launch + TMO
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_vld_cyc = -1;
  int  last_end_cyc = -1;
  int  frames_left [N];
  bit  eth_never = 1'b0;
  bit  eth_active = 1'b0;
  int  eth_owner, eth_len, byte_bad, nbytes;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int idx, input int len, input int at);
    ev_t e;
    e.kind = kind; e.idx = idx; e.len = len; e.at = at;
    sb.push_back(e);
  endtask

  task automatic set_len(input int i, input int len);
    req_len[ETH_LEN_W*i +: ETH_LEN_W] = ETH_LEN_W'(len);
  endtask

  task automatic pop_chk(input int kind, input int idx, input int len, output int exp_idx);
    ev_t e;
    exp_idx = idx;
    $display("cyc=%0d event kind=%0d requester=%0d len=%0d", cyc, kind, idx, len);
    if (sb.size() == 0) begin
      chk("unexpected_event", kind * 10 + idx, -1);
      return;
    end
    e = sb.pop_front();
    exp_idx = e.idx;
    chk("event_kind", kind, e.kind);
    chk("event_requester", idx, e.idx);
    if (e.kind == K_LAUNCH) chk("tx_count", len, e.len);
    if (e.at >= 0) chk("event_cycle", cyc, e.at);
    else if (e.at == -2) chk("timeout_cycle", cyc, last_vld_cyc + TMO);
    if (e.kind == K_DONE || e.at == -2) last_end_cyc = cyc;
  endtask

  task automatic release_req(input int i);
    if (frames_left[i] > 0) frames_left[i]--;
    if (frames_left[i] == 0) req[i] = 1'b0;
  endtask

  task automatic tick();
    int gidx;
    int eidx;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      #1;
      return;
    end
    if (eth_active) begin
      if (int'(tx_addr) == eth_len - 1) begin
        tx_busy    = 1'b0;
        eth_active = 1'b0;
        chk("frame_bytes_bad", byte_bad, 0);
        chk("frame_nbytes", nbytes, eth_len);
      end else begin
        tx_addr = tx_addr + 11'd1;
      end
    end
    if (tx_vld) begin
      gidx = -1;
      for (int i = N - 1; i >= 0; i--) if (grant[i]) gidx = i;
      chk("launch_grant_onehot", $countones(grant), 1);
      if (last_end_cyc >= 0) chk("ifg_spacing_ok", int'(cyc - last_end_cyc >= IFG + 3), 1);
      pop_chk(K_LAUNCH, gidx, int'(tx_count), eidx);
      last_vld_cyc = cyc;
      if (!eth_never) begin
        eth_active = 1'b1;
        eth_owner  = eidx;
        eth_len    = int'(tx_count);
        tx_busy    = 1'b1;
        tx_addr    = '0;
        byte_bad   = 0;
        nbytes     = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        pop_chk(K_DONE, i, 0, eidx);
        release_req(i);
      end
      if (err[i]) begin
        pop_chk(K_ERR, i, 0, eidx);
        release_req(i);
      end
    end
    #1;
    if (eth_active) begin
      nbytes++;
      if (tx_data !== buf_byte(eth_owner, int'(tx_addr))) byte_bad++;
    end
  endtask

  task automatic wait_q(input int n, input int budget);
    int b;
    b = budget;
    while (sb.size() > n && b > 0) begin
      tick();
      b--;
    end
    chk("scoreboard_within_budget", int'(sb.size() <= n), 1);
  endtask

  task automatic drain(input int budget);
    wait_q(0, budget);
    repeat (IFG + 6) tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_tx_vld"}, int'(tx_vld), 0);
    chk({tag, "_tx_count"}, int'(tx_count), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    tx_busy    = 1'b0;
    tx_addr    = '0;
    eth_active = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) frames_left[i] = 0;

    // Reset state
    repeat (3) tick();
    chk_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // Single requester 0, length 64: grant at +1, tx_vld at +2
    set_len(0, 64);
    frames_left[0] = 1;
    push(K_LAUNCH, 0, 64, cyc + 2);
    push(K_DONE, 0, 0, -1);
    req[0] = 1'b1;
    tick();
    chk("grant_latency", int'(grant), 1);
    chk("no_early_tx_vld", int'(tx_vld), 0);
    drain(400);

    // All four requesting, length 100: order 0,1,2,3,0 from a fresh reset
    do_reset();
    reset = 1'b0;
    last_end_cyc = -1;
    for (int i = 0; i < N; i++) begin
      set_len(i, 100);
      frames_left[i] = (i == 0) ? 2 : 1;
    end
    for (int f = 0; f < 5; f++) begin
      push(K_LAUNCH, f % N, 100, -1);
      push(K_DONE, f % N, 0, -1);
    end
    req = 4'b1111;
    drain(2000);

    // Requester 2 too short, next requester served
    set_len(2, 20);
    set_len(3, 64);
    frames_left[2] = 1;
    frames_left[3] = 1;
    push(K_ERR, 2, 0, cyc + 2);
    push(K_LAUNCH, 3, 64, -1);
    push(K_DONE, 3, 0, -1);
    req[2] = 1'b1;
    req[3] = 1'b1;
    drain(400);

    // Requester 2 too long, next requester served
    set_len(2, 1600);
    set_len(3, 80);
    frames_left[2] = 1;
    frames_left[3] = 1;
    push(K_ERR, 2, 0, cyc + 2);
    push(K_LAUNCH, 3, 80, -1);
    push(K_DONE, 3, 0, -1);
    req[2] = 1'b1;
    req[3] = 1'b1;
    drain(400);

    // eth never raises tx_busy: timeout err, gap, then normal service
    eth_never = 1'b1;
    set_len(1, 100);
    frames_left[1] = 1;
    push(K_LAUNCH, 1, 100, -1);
    push(K_ERR, 1, 0, -2);
    req[1] = 1'b1;
    wait_q(1, 20);
    eth_never = 1'b0;
    set_len(0, 64);
    frames_left[0] = 1;
    push(K_LAUNCH, 0, 64, -1);
    push(K_DONE, 0, 0, -1);
    req[0] = 1'b1;
    drain(600);

    // Reset during SEND: outputs clear, no done, requester 0 first afterwards
    set_len(2, 200);
    frames_left[2] = 1;
    push(K_LAUNCH, 2, 200, -1);
    req[2] = 1'b1;
    wait_q(0, 20);
    repeat (5) tick();
    chk("in_send_busy", int'(tx_busy), 1);
    do_reset();
    chk_outputs_zero("midframe_reset");
    set_len(0, 90);
    frames_left[0] = 1;
    push(K_LAUNCH, 0, 90, -1);
    push(K_DONE, 0, 0, -1);
    push(K_LAUNCH, 2, 200, -1);
    push(K_DONE, 2, 0, -1);
    req[0] = 1'b1;
    reset = 1'b0;
    last_end_cyc = -1;
    drain(1000);

    // req[1] dropped mid-frame: frame completes, tx_data tracks buffer 1
    set_len(1, 64);
    frames_left[1] = 1;
    push(K_LAUNCH, 1, 64, -1);
    push(K_DONE, 1, 0, -1);
    req[1] = 1'b1;
    wait_q(1, 20);
    repeat (3) tick();
    req[1] = 1'b0;
    drain(400);

    chk("idle_grant", int'(grant), 0);
    chk("idle_tx_data", int'(tx_data), 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
